// File: rtl/sr_pkg.sv
// sr_pkg: shared SR flag encodings, flag vector types and next-state helper
package sr_pkg;
    localparam int MAX_FLAGS = 32;
    typedef logic [MAX_FLAGS-1:0] flag_word_t;
    typedef enum logic [1:0] {
        SR_HOLD = 2'b00,
        SR_CLR  = 2'b01,
        SR_SET  = 2'b10,
        SR_BAD  = 2'b11
    } sr_cmd_t;
    // next value of one SR bit; the forbidden combination holds like 00
    function automatic logic sr_next(input logic cur, input logic s, input logic r);
        sr_cmd_t cmd;
        cmd = sr_cmd_t'({s, r});
        return cmd == SR_SET ? 1'b1 : cmd == SR_CLR ? 1'b0 : cur;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot winner search starting at a rotating pointer
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] elig,
    output logic [N-1:0] win,
    output logic         valid
);
    localparam int PW = N > 1 ? $clog2(N) : 1;
    logic [PW-1:0] ptr;
    logic [PW-1:0] widx;
    logic [PW-1:0] j;
    // first eligible index at or after ptr, wrapping
    always_comb begin
        win   = '0;
        widx  = ptr;
        valid = 1'b0;
        j     = '0;
        for (int i = 0; i < N; i++) begin
            j = PW'((int'(ptr) + i) % N);
            if (!valid && elig[j]) begin
                win[j] = 1'b1;
                widx   = j;
                valid  = 1'b1;
            end
        end
    end
    // pointer moves just past the winner, holds when nobody is eligible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (valid)
            ptr <= (widx == PW'(N - 1)) ? '0 : widx + 1'b1;
    end
endmodule

// File: rtl/sr_flag_arbiter.sv
// sr_flag_arbiter: round-robin arbitrated SR flag bank with forbidden-combination trapping
module sr_flag_arbiter
    import sr_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int FLAGS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*FLAGS-1:0] set_mask,
    input  logic [N_REQ*FLAGS-1:0] clr_mask,
    input  logic                   err_clr,
    output logic [N_REQ-1:0]       gnt,
    output logic [FLAGS-1:0]       flags,
    output logic [FLAGS-1:0]       err_bits,
    output logic [N_REQ-1:0]       err_src,
    output logic                   busy
);
    logic [N_REQ-1:0] win;
    logic             valid;
    logic [FLAGS-1:0] s;
    logic [FLAGS-1:0] r;
    logic [FLAGS-1:0] bad;
    logic [FLAGS-1:0] flags_next;

    // a requester being granted this cycle is masked so a held req cannot apply twice
    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .elig  (req & ~gnt),
        .win   (win),
        .valid (valid)
    );

    // select the winner's masks (zero when idle) and evaluate each SR bit
    always_comb begin
        s          = '0;
        r          = '0;
        bad        = '0;
        flags_next = flags;
        for (int i = 0; i < N_REQ; i++) begin
            s = s | (win[i] ? set_mask[i*FLAGS +: FLAGS] : '0);
            r = r | (win[i] ? clr_mask[i*FLAGS +: FLAGS] : '0);
        end
        for (int k = 0; k < FLAGS; k++) begin
            bad[k]        = sr_cmd_t'({s[k], r[k]}) == SR_BAD;
            flags_next[k] = sr_next(flags[k], s[k], r[k]);
        end
    end

    // grant pulse, bank write and sticky error capture; new errors win over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt      <= '0;
            busy     <= 1'b0;
            flags    <= '0;
            err_bits <= '0;
            err_src  <= '0;
        end else begin
            gnt      <= win;
            busy     <= valid;
            flags    <= flags_next;
            err_bits <= (err_clr ? '0 : err_bits) | bad;
            err_src  <= (err_clr ? '0 : err_src) | (|bad ? win : '0);
        end
    end
endmodule

// File: tb/tb_sr_flag_arbiter.sv
// tb_sr_flag_arbiter: scoreboard bench with a behavioural model of the flag arbiter
module tb_sr_flag_arbiter;
    localparam int N = 4;
    localparam int F = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*F-1:0] set_mask = '0;
    logic [N*F-1:0] clr_mask = '0;
    logic           err_clr = 1'b0;
    logic [N-1:0]   gnt;
    logic [F-1:0]   flags;
    logic [F-1:0]   err_bits;
    logic [N-1:0]   err_src;
    logic           busy;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [F-1:0] flags;
        logic [F-1:0] eb;
        logic [N-1:0] es;
        logic         busy;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int errors = 0;

    logic [F-1:0] m_flags;
    logic [F-1:0] m_eb;
    logic [N-1:0] m_es;
    logic [N-1:0] m_gnt;
    logic         m_busy;
    int           m_ptr;

    sr_flag_arbiter #(.N_REQ(N), .FLAGS(F)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .set_mask (set_mask),
        .clr_mask (clr_mask),
        .err_clr  (err_clr),
        .gnt      (gnt),
        .flags    (flags),
        .err_bits (err_bits),
        .err_src  (err_src),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_flags = '0;
        m_eb    = '0;
        m_es    = '0;
        m_gnt   = '0;
        m_busy  = 1'b0;
        m_ptr   = 0;
    endtask

    // apply inputs for one cycle and predict the state after the next posedge
    task automatic drive(input logic [N-1:0] r, input logic [N*F-1:0] s, input logic [N*F-1:0] c, input logic ec);
        logic [N-1:0] elig;
        logic [F-1:0] ws, wc, bad;
        int w;
        @(negedge clk);
        req = r;
        set_mask = s;
        clr_mask = c;
        err_clr = ec;
        elig = r & ~m_gnt;
        w = -1;
        for (int k = 0; k < N; k++)
            if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        if (ec) begin
            m_eb = '0;
            m_es = '0;
        end
        if (w >= 0) begin
            ws = s[w*F +: F];
            wc = c[w*F +: F];
            bad = ws & wc;
            m_flags = (m_flags & ~(wc & ~ws)) | (ws & ~wc);
            m_eb = m_eb | bad;
            if (bad != 0) m_es[w] = 1'b1;
            m_gnt = N'(1) << w;
            m_ptr = (w + 1) % N;
            m_busy = 1'b1;
        end else begin
            m_gnt = '0;
            m_busy = 1'b0;
        end
        q.push_back('{gnt: m_gnt, flags: m_flags, eb: m_eb, es: m_es, busy: m_busy});
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // asynchronous reset in the middle of a cycle with traffic on the inputs
    task automatic do_reset(input logic [N-1:0] r_hold);
        @(negedge clk);
        #2;
        req = r_hold;
        set_mask = N*F'($urandom);
        clr_mask = N*F'($urandom);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("rst_flags", 32'(flags), 0);
        check("rst_err_bits", 32'(err_bits), 0);
        check("rst_err_src", 32'(err_src), 0);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_busy", 32'(busy), 0);
        req = '0;
        set_mask = '0;
        clr_mask = '0;
        err_clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // monitor: compare every cycle that has a pending expectation
    always @(posedge clk) begin
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check("sb_gnt", 32'(gnt), 32'(e.gnt));
            check("sb_flags", 32'(flags), 32'(e.flags));
            check("sb_err_bits", 32'(err_bits), 32'(e.eb));
            check("sb_err_src", 32'(err_src), 32'(e.es));
            check("sb_busy", 32'(busy), 32'(e.busy));
        end
    end

    logic [N-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        logic [N-1:0] p, r;
        model_reset();
        #12;
        check("init_flags", 32'(flags), 0);
        check("init_gnt", 32'(gnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(4'b0100, 32'h000F_0000, 32'h0, 1'b0);
        settle();
        check("single_gnt", 32'(gnt), 32'h4);
        check("single_set", 32'(flags), 32'h0F);
        drive(4'b0000, 32'h0, 32'h0, 1'b0);
        drive(4'b0100, 32'h0, 32'h0003_0000, 1'b0);
        settle();
        check("single_clr", 32'(flags), 32'h0C);

        do_reset(4'b0000);
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 32'h0804_0201, 32'h0, 1'b0);
            settle();
            check("rr_gnt", 32'(gnt), 32'(rr_exp[i]));
        end
        check("rr_flags", 32'(flags), 32'h0F);

        do_reset(4'b1111);
        drive(4'b0010, 32'h0000_8000, 32'h0, 1'b0);
        drive(4'b0000, 32'h0, 32'h0, 1'b0);
        drive(4'b0010, 32'h0000_8100, 32'h0000_8000, 1'b0);
        settle();
        check("bad_flags", 32'(flags), 32'h81);
        check("bad_err_bits", 32'(err_bits), 32'h80);
        check("bad_err_src", 32'(err_src), 32'h2);
        drive(4'b0001, 32'h0000_0001, 32'h0000_0001, 1'b1);
        settle();
        check("clr_vs_new_bits", 32'(err_bits), 32'h01);
        check("clr_vs_new_src", 32'(err_src), 32'h1);

        do_reset(4'b0101);
        drive(4'b0011, 32'h0000_FF00, 32'h0000_FF00, 1'b0);
        settle();
        check("nonwin_gnt", 32'(gnt), 32'h1);
        check("nonwin_no_err", 32'(err_bits), 32'h0);
        drive(4'b0010, 32'h0000_FF00, 32'h0000_FF00, 1'b0);
        settle();
        check("win_err_bits", 32'(err_bits), 32'hFF);
        check("win_err_src", 32'(err_src), 32'h2);
        check("win_flags_held", 32'(flags), 32'h0);

        do_reset(4'b0000);
        drive(4'b0001, 32'h0000_00A5, 32'h0, 1'b0);
        settle();
        check("pre_rst_flags", 32'(flags), 32'hA5);
        do_reset(4'b1111);
        drive(4'b0110, 32'h0, 32'h0, 1'b0);
        settle();
        check("post_rst_gnt", 32'(gnt), 32'h2);

        p = '0;
        for (int c = 0; c < 400; c++) begin
            r = ~m_gnt & (p | (N'($urandom) & N'($urandom)));
            drive(r, $urandom & $urandom, $urandom & $urandom & $urandom, $urandom_range(0, 7) == 0);
            p = r;
            if (c == 200) begin
                do_reset(N'($urandom));
                p = '0;
            end
        end
        drive('0, '0, '0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
